div_unit: RTL and testbench



---
 rtl/div_unit.sv | 101 ++++++++++
 tb/tb_div_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: 32-bit iterative radix-2 restoring divider for DIV/DIVU, 32 steps per result
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [63:0] div, div_n, res_n;
  logic [31:0] dvs, dvs_n, a_mag, b_mag, q, r;
  logic        qs, qs_n, rs, rs_n, rdy_n;
  logic [64:0] sh;
  logic [32:0] diff;
  logic [63:0] step;
  assign a_mag = signed_div_i && opdata1_i[31] ? -opdata1_i : opdata1_i;
  assign b_mag = signed_div_i && opdata2_i[31] ? -opdata2_i : opdata2_i;
  // div holds {partial remainder, unconsumed dividend bits / quotient bits}
  assign sh    = {div, 1'b0};
  assign diff  = sh[64:32] - {1'b0, dvs};
  assign step  = diff[32] ? sh[63:0] : {diff[31:0], sh[31:1], 1'b1};
  assign q     = qs ? -step[31:0] : step[31:0];
  assign r     = rs ? -step[63:32] : step[63:32];
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div;
    dvs_n   = dvs;
    qs_n    = qs;
    rs_n    = rs;
    res_n   = result_o;
    rdy_n   = ready_o;
    case (state)
      FREE:
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) state_n = BYZERO;
          else begin
            state_n = ON;
            cnt_n   = 6'd0;
            div_n   = {32'd0, a_mag};
            dvs_n   = b_mag;
            qs_n    = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            rs_n    = signed_div_i && opdata1_i[31];
          end
        end
      BYZERO: begin
        state_n = annul_i ? FREE : END;
        res_n   = 64'd0;
        rdy_n   = !annul_i;
      end
      ON:
        if (annul_i) begin
          state_n = FREE;
          res_n   = 64'd0;
          rdy_n   = 1'b0;
        end else begin
          div_n = step;
          cnt_n = cnt + 6'd1;
          if (cnt == 6'd31) begin
            state_n = END;
            res_n   = {r, q};
            rdy_n   = 1'b1;
          end
        end
      END:
        if (!start_i) begin
          state_n = FREE;
          res_n   = 64'd0;
          rdy_n   = 1'b0;
        end
      default: state_n = FREE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      div      <= 64'd0;
      dvs      <= 32'd0;
      qs       <= 1'b0;
      rs       <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      div      <= div_n;
      dvs      <= dvs_n;
      qs       <= qs_n;
      rs       <= rs_n;
      result_o <= res_n;
      ready_o  <= rdy_n;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an arithmetic reference model
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, sd, start, annul;
  logic [31:0] a, b;
  logic [63:0] res;
  logic        rdy;
  int          tests = 0;
  int          fails = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .signed_div_i(sd), .opdata1_i(a), .opdata2_i(b),
    .start_i(start), .annul_i(annul), .result_o(res), .ready_o(rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] x, input logic [31:0] y);
    longint n, d, qq, rr;
    if (y == 32'd0) return 64'd0;
    n  = s ? {{32{x[31]}}, x} : {32'd0, x};
    d  = s ? {{32{y[31]}}, y} : {32'd0, y};
    qq = n / d;
    rr = n % d;
    return {rr[31:0], qq[31:0]};
  endfunction

  task automatic run_div(input bit s, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic [63:0] r);
    @(negedge clk);
    sd = s; a = x; b = y; start = 1'b1; annul = 1'b0;
    @(posedge clk);
    #1;
    a = $urandom;
    b = $urandom;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (rdy) break;
    end
    r = res;
  endtask

  task automatic drop(output logic rd, output logic [63:0] rr);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    rd = rdy;
    rr = res;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; annul = 1'b0; sd = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (rdy !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", rdy); end
    tests++;
    if (res !== 64'd0) begin fails++; $display("FAIL reset_result got %h want 0", res); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    bit          ts [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] tx [6] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h80000000, 32'h12345678};
    logic [31:0] ty [6] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [63:0] te [6] = '{{32'd2, 32'd14}, {32'hFFFFFFFF, 32'hFFFFFFFD}, {32'd1, 32'hFFFFFFFD},
                            {32'h0, 32'h80000000}, {32'h80000000, 32'h0}, 64'd0};
    int          tl [6] = '{32, 32, 32, 32, 32, 1};
    int          lat;
    logic [63:0] r, rr;
    logic        rd;
    for (int i = 0; i < 6; i++) begin
      run_div(ts[i], tx[i], ty[i], lat, r);
      tests++;
      if (lat != tl[i]) begin fails++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, tl[i]); end
      tests++;
      if (r !== te[i]) begin fails++; $display("FAIL dir%0d_result got %h want %h", i, r, te[i]); end
      @(negedge clk);
      annul = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (rdy !== 1'b1 || res !== te[i]) begin
        fails++; $display("FAIL dir%0d_hold got rdy=%b res=%h want rdy=1 res=%h", i, rdy, res, te[i]);
      end
      annul = 1'b0;
      drop(rd, rr);
      tests++;
      if (rd !== 1'b0 || rr !== 64'd0) begin
        fails++; $display("FAIL dir%0d_drop got rdy=%b res=%h want rdy=0 res=0", i, rd, rr);
      end
    end
  endtask

  task automatic test_random;
    int          lat;
    bit          s;
    logic [31:0] x, y;
    logic [63:0] r, rr, e;
    logic        rd;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) != 0 ? $urandom : $urandom_range(1, 255));
      if (i % 10 == 9) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      e = ref_div(s, x, y);
      run_div(s, x, y, lat, r);
      tests++;
      if (lat != (y == 32'd0 ? 1 : 32)) begin
        fails++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, y == 32'd0 ? 1 : 32);
      end
      tests++;
      if (r !== e) begin fails++; $display("FAIL rand%0d_result s=%0d %h/%h got %h want %h", i, s, x, y, r, e); end
      drop(rd, rr);
      tests++;
      if (rd !== 1'b0 || rr !== 64'd0) begin
        fails++; $display("FAIL rand%0d_drop got rdy=%b res=%h want rdy=0 res=0", i, rd, rr);
      end
    end
  endtask

  task automatic test_annul;
    int          lat, seen;
    logic [63:0] r, rr;
    logic        rd;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sd = 1'b0; a = 32'hDEADBEEF; b = (k == 2) ? 32'd0 : 32'd3; start = 1'b1; annul = 1'b0;
      @(posedge clk);
      if (k != 2) repeat (10) @(posedge clk);
      @(negedge clk);
      annul = 1'b1;
      start = (k == 1);
      @(posedge clk);
      #1;
      tests++;
      if (rdy !== 1'b0 || res !== 64'd0) begin
        fails++; $display("FAIL annul%0d_cancel got rdy=%b res=%h want rdy=0 res=0", k, rdy, res);
      end
      @(negedge clk);
      annul = 1'b0;
      start = 1'b0;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (rdy) seen++; end
      tests++;
      if (seen != 0) begin fails++; $display("FAIL annul%0d_noready got %0d ready cycles want 0", k, seen); end
    end
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, lat, r);
    tests++;
    if (lat != 32) begin fails++; $display("FAIL annul_after_latency got %0d want 32", lat); end
    tests++;
    if (r !== {32'hF, 32'h0FFFFFFF}) begin fails++; $display("FAIL annul_after_result got %h want %h", r, {32'hF, 32'h0FFFFFFF}); end
    drop(rd, rr);
    @(negedge clk);
    sd = 1'b0; a = 32'd50; b = 32'd5; start = 1'b1; annul = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    @(posedge clk);
    lat = 0;
    while (lat < 40) begin @(posedge clk); lat++; #1; if (rdy) break; end
    tests++;
    if (lat != 32) begin fails++; $display("FAIL free_annul_latency got %0d want 32", lat); end
    tests++;
    if (res !== {32'd0, 32'd10}) begin fails++; $display("FAIL free_annul_result got %h want %h", res, {32'd0, 32'd10}); end
    drop(rd, rr);
  endtask

  task automatic test_rst_mid;
    int          lat;
    logic [63:0] r, rr;
    logic        rd;
    @(negedge clk);
    sd = 1'b1; a = 32'hF0000000; b = 32'd9; start = 1'b1; annul = 1'b0;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (rdy !== 1'b0 || res !== 64'd0) begin
      fails++; $display("FAIL rst_on got rdy=%b res=%h want rdy=0 res=0", rdy, res);
    end
    @(negedge clk);
    rst = 1'b0;
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, lat, r);
    tests++;
    if (r !== ref_div(1'b1, 32'hFFFFFF9C, 32'd7)) begin
      fails++; $display("FAIL rst_end_prep got %h want %h", r, ref_div(1'b1, 32'hFFFFFF9C, 32'd7));
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (rdy !== 1'b0 || res !== 64'd0) begin
      fails++; $display("FAIL rst_end got rdy=%b res=%h want rdy=0 res=0", rdy, res);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    run_div(1'b0, 32'd1000003, 32'd97, lat, r);
    tests++;
    if (lat != 32 || r !== ref_div(1'b0, 32'd1000003, 32'd97)) begin
      fails++; $display("FAIL rst_recover got lat=%0d res=%h want lat=32 res=%h", lat, r, ref_div(1'b0, 32'd1000003, 32'd97));
    end
    drop(rd, rr);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_annul;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
